// File: rtl/paquete_vga_rtc.sv
// Shared constants and helpers for the RTC pixel generator.
// Contents: visible-area size, glyph codes, character-cell geometry,
// edit-field codes and the char-index -> glyph / field mapping helpers.
package paquete_vga_rtc;

  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  // One 8x16 glyph scaled by 4 occupies a 32x64 pixel cell.
  localparam int CHAR_W      = 32;
  localparam int CHAR_H      = 64;
  localparam int SCALE_SHIFT = 2;

  typedef enum logic [1:0] {
    CAMPO_NINGUNO = 2'd0,
    CAMPO_HORA    = 2'd1,
    CAMPO_MIN     = 2'd2,
    CAMPO_SEG     = 2'd3
  } campo_t;

  // Non-decimal nibbles render as the blank glyph.
  function automatic logic [3:0] bcd_a_glifo(input logic [3:0] d);
    return (d > 4'd9) ? GLYPH_BLANK : d;
  endfunction

  // "HH:MM:SS" layout: char index 0..7 -> glyph code.
  function automatic logic [3:0] glifo_de_char(input logic [2:0] c,
                                               input logic [7:0] h,
                                               input logic [7:0] m,
                                               input logic [7:0] s);
    logic [3:0] g;
    case (c)
      3'd0:    g = bcd_a_glifo(h[7:4]);
      3'd1:    g = bcd_a_glifo(h[3:0]);
      3'd3:    g = bcd_a_glifo(m[7:4]);
      3'd4:    g = bcd_a_glifo(m[3:0]);
      3'd6:    g = bcd_a_glifo(s[7:4]);
      3'd7:    g = bcd_a_glifo(s[3:0]);
      default: g = GLYPH_COLON;
    endcase
    return g;
  endfunction

  // Field owning each char; colons belong to no field so they never blink.
  function automatic campo_t campo_de_char(input logic [2:0] c);
    campo_t f;
    case (c)
      3'd0, 3'd1: f = CAMPO_HORA;
      3'd3, 3'd4: f = CAMPO_MIN;
      3'd6, 3'd7: f = CAMPO_SEG;
      default:    f = CAMPO_NINGUNO;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/generador_pixeles_rtc_font.sv
// font_rom_digitos: 16 glyphs x 16 rows x 8 bits, digits 0-9 and colon (10);
// unused glyphs are all zero. Address = {glyph[3:0], row[3:0]}; the row is
// returned registered (1-cycle latency), MSB = leftmost pixel.
// Ports: CLK, RESET (sync, active high, clears output), direccion, fila.
module font_rom_digitos (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] direccion,
  output logic [7:0] fila
);

  // Each entry lists rows 0..15 left to right, so row r is element [15-r].
  localparam logic [15:0][7:0] FUENTE [16] = '{
    128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000,  // 0
    128'h0000_1838_7818_1818_1818_187E_0000_0000,  // 1
    128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000,  // 2
    128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000,  // 3
    128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000,  // 4
    128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000,  // 5
    128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000,  // 6
    128'h0000_FEC6_0606_0C18_3030_3030_0000_0000,  // 7
    128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000,  // 8
    128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000,  // 9
    128'h0000_0000_1818_0000_0018_1800_0000_0000,  // colon
    '0, '0, '0, '0, '0
  };

  always_ff @(posedge CLK) begin
    if (RESET) fila <= '0;
    else       fila <= FUENTE[direccion[7:4]][4'd15 - direccion[3:0]];
  end

endmodule

// File: rtl/generador_pixeles_rtc.sv
// generador_pixeles_rtc: renders the RTC time "HH:MM:SS" as 4x-scaled 8x16
// glyphs at (X0,Y0) over a solid background, 3-CLK pipeline with syncs
// realigned to the colour output. Time is snapshotted on each vsync fall so
// digits never tear; the field selected by campo_edit blinks.
// Ports: CLK, RESET (sync, active high), pixel_X/pixel_Y (synchroniser
// counters), sincro_horiz/sincro_vert (active-low syncs in), hora/min/seg_bcd,
// campo_edit (0 none, 1 h, 2 m, 3 s), rgb (R4G4B4), hsync_out, vsync_out.
// Build option: define BORDE_MARCO_EN to draw a COLOR_FG frame on the
// outermost visible rows/columns.
module generador_pixeles_rtc
  import paquete_vga_rtc::*;
#(
  parameter int          X0           = 192,
  parameter int          Y0           = 208,
  parameter logic [11:0] COLOR_FG     = 12'hFFF,
  parameter logic [11:0] COLOR_BG     = 12'h008,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  pixel_X,
  input  logic [9:0]  pixel_Y,
  input  logic        sincro_horiz,
  input  logic        sincro_vert,
  input  logic [7:0]  hora_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  seg_bcd,
  input  logic [1:0]  campo_edit,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [10:0] X_MIN        = 11'(X0);
  localparam logic [10:0] X_MAX        = 11'(X0 + 8 * CHAR_W);
  localparam logic [10:0] Y_MIN        = 11'(Y0);
  localparam logic [10:0] Y_MAX        = 11'(Y0 + CHAR_H);
  localparam logic [7:0]  ULTIMO_FRAME = 8'(BLINK_FRAMES - 1);

  logic [10:0] x_ext, y_ext;
  logic [7:0]  dx;
  logic [5:0]  dy;
  logic        video, en_caja;

  // Frame snapshot and blink state
  logic        vs_prev, evento;
  logic [7:0]  snap_hora, snap_min, snap_seg;
  logic [7:0]  cnt_frames;
  logic        fase_blink;

  // Pipeline
  logic        video_s1, caja_s1, hs_s1, vs_s1;
  logic [2:0]  char_s1, col_s1;
  logic [3:0]  fila_s1;
  logic        video_s2, caja_s2, hs_s2, vs_s2, oculto_s2;
  logic [2:0]  col_s2;
  logic [7:0]  fila_rom;
  logic        oculto, pixel_on;
  campo_t      campo_sel;

  always_comb begin
    x_ext   = {1'b0, pixel_X};
    y_ext   = {1'b0, pixel_Y};
    // Offsets wrap outside the box; only used when en_caja is true.
    dx      = 8'(pixel_X - X_MIN[9:0]);
    dy      = 6'(pixel_Y - Y_MIN[9:0]);
    video   = (x_ext < 11'(H_VISIBLE)) && (y_ext < 11'(V_VISIBLE));
    en_caja = (x_ext >= X_MIN) && (x_ext < X_MAX) &&
              (y_ext >= Y_MIN) && (y_ext < Y_MAX);
    evento  = vs_prev && !sincro_vert;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_prev    <= 1'b0;
      snap_hora  <= '0;
      snap_min   <= '0;
      snap_seg   <= '0;
      cnt_frames <= '0;
      fase_blink <= 1'b1;
    end else begin
      vs_prev <= sincro_vert;
      if (evento) begin
        snap_hora <= hora_bcd;
        snap_min  <= min_bcd;
        snap_seg  <= seg_bcd;
        if (cnt_frames == ULTIMO_FRAME) begin
          cnt_frames <= '0;
          fase_blink <= ~fase_blink;
        end else begin
          cnt_frames <= cnt_frames + 8'd1;
        end
      end
    end
  end

  // S1: geometry and syncs
`ifdef BORDE_MARCO_EN
  logic borde_s1, borde_s2;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      video_s1 <= 1'b0;
      caja_s1  <= 1'b0;
      char_s1  <= '0;
      col_s1   <= '0;
      fila_s1  <= '0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
`ifdef BORDE_MARCO_EN
      borde_s1 <= 1'b0;
`endif
    end else begin
      video_s1           <= video;
      caja_s1            <= en_caja;
      {char_s1, col_s1}  <= 6'(dx >> SCALE_SHIFT);
      fila_s1            <= 4'(dy >> SCALE_SHIFT);
      hs_s1              <= sincro_horiz;
      vs_s1              <= sincro_vert;
`ifdef BORDE_MARCO_EN
      borde_s1 <= video && (pixel_X == 10'd0 || pixel_X == 10'(H_VISIBLE - 1) ||
                            pixel_Y == 10'd0 || pixel_Y == 10'(V_VISIBLE - 1));
`endif
    end
  end

  // S2: glyph row from ROM; blanking decided here so it travels with the row
  always_comb begin
    campo_sel = campo_t'(campo_edit);
    oculto    = !fase_blink && (campo_sel != CAMPO_NINGUNO) &&
                (campo_de_char(char_s1) == campo_sel);
  end

  font_rom_digitos u_fuente (
    .CLK       (CLK),
    .RESET     (RESET),
    .direccion ({glifo_de_char(char_s1, snap_hora, snap_min, snap_seg), fila_s1}),
    .fila      (fila_rom)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      video_s2  <= 1'b0;
      caja_s2   <= 1'b0;
      col_s2    <= '0;
      oculto_s2 <= 1'b0;
      hs_s2     <= 1'b1;
      vs_s2     <= 1'b1;
`ifdef BORDE_MARCO_EN
      borde_s2  <= 1'b0;
`endif
    end else begin
      video_s2  <= video_s1;
      caja_s2   <= caja_s1;
      col_s2    <= col_s1;
      oculto_s2 <= oculto;
      hs_s2     <= hs_s1;
      vs_s2     <= vs_s1;
`ifdef BORDE_MARCO_EN
      borde_s2  <= borde_s1;
`endif
    end
  end

  // S3: colour select
  always_comb pixel_on = fila_rom[3'd7 - col_s2];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hs_s2;
      vsync_out <= vs_s2;
      if (!video_s2)
        rgb <= '0;
`ifdef BORDE_MARCO_EN
      else if (borde_s2)
        rgb <= COLOR_FG;
`endif
      else if (caja_s2 && pixel_on && !oculto_s2)
        rgb <= COLOR_FG;
      else
        rgb <= COLOR_BG;
    end
  end

endmodule

// File: tb/tb_generador_pixeles_rtc.sv
// Testbench for generador_pixeles_rtc: directed pixels, expected outputs
// queued with their due cycle, checked by an independent monitor.
module tb_generador_pixeles_rtc;

  localparam int          X0 = 192;
  localparam int          Y0 = 208;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h008;
`ifdef BORDE_MARCO_EN
  localparam logic [11:0] BORDE = FG;
`else
  localparam logic [11:0] BORDE = BG;
`endif

  // Glyph column masks, bit r = glyph row r lit
  localparam logic [15:0] M1_C1     = 16'h0810;  // '1' column 1
  localparam logic [15:0] M1_C3     = 16'h0FFC;  // '1' column 3
  localparam logic [15:0] M3_C1     = 16'h0C0C;  // '3' column 1
  localparam logic [15:0] M4_C0     = 16'h00C0;  // '4' column 0
  localparam logic [15:0] M6_C0     = 16'h07F0;  // '6' column 0
  localparam logic [15:0] M7_C0     = 16'h000C;  // '7' column 0
  localparam logic [15:0] MCOLON_C3 = 16'h0630;  // ':' column 3

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  pixel_X = '0, pixel_Y = '0;
  logic        sincro_horiz = 1'b1, sincro_vert = 1'b1;
  logic [7:0]  hora_bcd = 8'h12, min_bcd = 8'h34, seg_bcd = 8'h56;
  logic [1:0]  campo_edit = 2'd0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  generador_pixeles_rtc #(.BLINK_FRAMES(2)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .pixel_X      (pixel_X),
    .pixel_Y      (pixel_Y),
    .sincro_horiz (sincro_horiz),
    .sincro_vert  (sincro_vert),
    .hora_bcd     (hora_bcd),
    .min_bcd      (min_bcd),
    .seg_bcd      (seg_bcd),
    .campo_edit   (campo_edit),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_exp(input int unsigned due, input logic [11:0] er,
                          input logic ehs, input logic evs, input string nm);
    exp_t e;
    e.due = due; e.rgb = er; e.hs = ehs; e.vs = evs; e.name = nm;
    sb.push_back(e);
  endtask

  // Apply one pixel for one CLK; lat>0 queues its expected output lat cycles later.
  task automatic drive(input int x, input int y, input logic hs, input logic vs,
                       input int lat, input logic [11:0] er, input logic ehs,
                       input logic evs, input string nm);
    pixel_X = 10'(x);
    pixel_Y = 10'(y);
    sincro_horiz = hs;
    sincro_vert  = vs;
    if (lat > 0) push_exp(cyc + int'(lat), er, ehs, evs, nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(700, 500, 1'b1, 1'b1, 0, '0, 1'b1, 1'b1, "");
  endtask

  task automatic frame_evt();
    drive(700, 500, 1'b1, 1'b0, 0, '0, 1'b1, 1'b1, "");
    idle();
  endtask

  // Sweep all 64 pixel rows of one glyph column of char ch.
  task automatic columna(input int ch, input int col, input logic [15:0] mask,
                         input string nm);
    for (int y = 0; y < 64; y++)
      drive(X0 + ch * 32 + col * 4 + (y % 4), Y0 + y, 1'b1, 1'b1, 3,
            mask[y / 4] ? FG : BG, 1'b1, 1'b1, nm);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        tests++;
        if (e.due != cyc) begin
          fails++;
          $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.due, cyc);
        end else if (rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
          fails++;
          $display("FAIL %s @cyc %0d: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                   e.name, cyc, rgb, hsync_out, vsync_out, e.rgb, e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    logic [7:0] pat_h;
    logic [7:0] pat_v;
    logic       hid;
    pat_h = 8'b1011_0010;
    pat_v = 8'b0110_1101;
    @(posedge CLK);
    #1;

    // Reset held 5 CLK with active syncs on the inputs
    RESET = 1'b1;
    for (int i = 0; i < 5; i++)
      drive(1, 1, 1'b0, 1'b0, 1, '0, 1'b1, 1'b1, "reset");
    RESET = 1'b0;
    push_exp(cyc + 1, '0, 1'b1, 1'b1, "refill1");
    push_exp(cyc + 2, '0, 1'b1, 1'b1, "refill2");
    drive(1, 1, 1'b0, 1'b0, 3, BG, 1'b0, 1'b0, "first_px");
    for (int i = 0; i < 8; i++)
      drive(700, 100, pat_h[i], pat_v[i], 3, '0, pat_h[i], pat_v[i], "sync_track");
    idle();
    frame_evt();

    // Render 12:34:56
    columna(0, 1, M1_C1, "h_tens_c1");
    columna(0, 3, M1_C3, "h_tens_c3");
    columna(2, 3, MCOLON_C3, "colon_c3");
    drive(700, Y0 + 8, 1'b1, 1'b1, 3, '0, 1'b1, 1'b1, "offscreen_x");
    drive(X0 + 4, 500, 1'b1, 1'b1, 3, '0, 1'b1, 1'b1, "offscreen_y");
    drive(X0 - 1, Y0 + 8, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "left_of_box");
    drive(X0 + 256, Y0 + 8, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "right_of_box");
    drive(X0 + 12, Y0 - 1, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "above_box");
    drive(X0 + 12, Y0 + 64, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "below_box");

    // Snapshot: mid-frame change is invisible until the next vsync fall
    drive(700, 100, 1'b1, 1'b1, 0, '0, 1'b1, 1'b1, "");
    seg_bcd = 8'h57;
    columna(7, 0, M6_C0, "snap_hold");
    frame_evt();
    columna(7, 0, M7_C0, "snap_new");

    // Invalid BCD tens nibble renders blank
    min_bcd = 8'hA3;
    frame_evt();
    columna(3, 1, 16'h0000, "inv_c1");
    columna(3, 3, 16'h0000, "inv_c3");
    columna(4, 1, M3_C1, "min_units_3");

    // Blink of the minutes field
    min_bcd = 8'h34;
    seg_bcd = 8'h56;
    campo_edit = 2'd2;
    repeat (4) idle();
    RESET = 1'b1;
    repeat (2) idle();
    RESET = 1'b0;
    idle();
    for (int n = 1; n <= 5; n++) begin
      frame_evt();
      hid = (n == 2 || n == 3);
      columna(3, 1, hid ? 16'h0000 : M3_C1, "blink_min_tens");
      columna(4, 0, hid ? 16'h0000 : M4_C0, "blink_min_units");
      columna(0, 3, M1_C3, "blink_hours");
      columna(2, 3, MCOLON_C3, "blink_colon");
      columna(7, 0, M6_C0, "blink_seconds");
    end
    campo_edit = 2'd0;

    // Visible-area edges
    drive(0, 0, 1'b1, 1'b1, 3, BORDE, 1'b1, 1'b1, "edge_0_0");
    drive(639, 479, 1'b1, 1'b1, 3, BORDE, 1'b1, 1'b1, "edge_639_479");
    drive(639, 0, 1'b1, 1'b1, 3, BORDE, 1'b1, 1'b1, "edge_639_0");
    drive(1, 1, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "inner_1_1");
    drive(638, 478, 1'b1, 1'b1, 3, BG, 1'b1, 1'b1, "inner_638_478");
    drive(640, 479, 1'b1, 1'b1, 3, '0, 1'b1, 1'b1, "beyond_640");

    for (int i = 0; i < 10 && sb.size() > 0; i++) idle();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks never reached", sb.size());
      fails += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/generador_pixeles_rtc.md
Name: generador_pixeles_rtc

Overview:
- Pixel generator directly downstream of the VGA 640x480 synchroniser.
- Consumes the pixel coordinates and the active-low syncs, and renders the RTC time "HH:MM:SS" as scaled 8x16 glyphs on a solid background.
- Drives the 12-bit VGA RGB and the realigned syncs to the board connector.
- Snapshots the time once per frame so digits never tear, and blinks the field under edit.

Parameters:
- X0, 192: left pixel column of the text box.
- Y0, 208: top pixel row of the text box.
- COLOR_FG, 12'hFFF: glyph colour (R4G4B4).
- COLOR_BG, 12'h008: background colour inside the visible area.
- BLINK_FRAMES, 30: frames per blink half-period, 2..255.

Ports:
- CLK, input, 1: 100 MHz system clock.
- RESET, input, 1: synchronous, active-high reset.
- pixel_X, input, 10: horizontal counter 0..799 from the synchroniser.
- pixel_Y, input, 10: vertical counter 0..524 from the synchroniser.
- sincro_horiz, input, 1: active-low hsync from the synchroniser.
- sincro_vert, input, 1: active-low vsync from the synchroniser.
- hora_bcd, input, 8: hours as 2 BCD digits, tens in [7:4].
- min_bcd, input, 8: minutes as 2 BCD digits.
- seg_bcd, input, 8: seconds as 2 BCD digits.
- campo_edit, input, 2: field to blink: 0 none, 1 hours, 2 minutes, 3 seconds.
- rgb, output, 12: VGA colour, registered.
- hsync_out, output, 1: hsync delayed to match rgb, active low.
- vsync_out, output, 1: vsync delayed to match rgb, active low.

Behaviour:
- Only one clock (CLK); RESET is synchronous and active-high. All registers update on the rising CLK edge only.
- Reset values: rgb=0, hsync_out=1, vsync_out=1, snapshot registers=0, frame counter=0, blink phase=visible (1), all pipeline registers cleared (syncs cleared to 1).
- Pipeline, fixed latency of 3 CLK, with no clock enable. A pixel is held 4 CLK by the synchroniser, so a 3-cycle shift is acceptable.
  - S1 registers: video_on = (X<640 && Y<480); in_box = (X0 <= X < X0+256) && (Y0 <= Y < Y0+64); char index = (X-X0)>>5; glyph row = ((Y-Y0)>>2)&15; bit column = ((X-X0)>>2)&7; both syncs.
  - S2: the font ROM read (synchronous) returns the 8-bit row. Attributes and syncs are delayed one more register.
  - S3: registers rgb, hsync_out and vsync_out.
- Glyph mapping by char index:
  - 0: hours tens; 1: hours units; 2: colon; 3: minutes tens; 4: minutes units; 5: colon; 6: seconds tens; 7: seconds units.
  - Glyph code 10 is the colon; code 15 is blank (all-zero rows).
  - A nibble greater than 9 renders as glyph 15.
- Pixel on = ROM row bit [7-column] (MSB is the leftmost pixel).
- rgb selection:
  - not video_on: 0;
  - in_box and pixel on and not hidden: COLOR_FG;
  - otherwise: COLOR_BG.
- Frame event: the sincro_vert falling edge (1->0), detected with one internal register.
  - On the event, hora/min/seg are latched into the snapshot registers. Rendering uses only the snapshot, so an input change mid-frame is invisible until the next frame.
- Blink:
  - The frame counter increments on each frame event.
  - When it equals BLINK_FRAMES-1 on an event, the counter goes to 0 and the blink phase toggles.
  - Hidden = (blink phase==0) && the char belongs to the campo_edit field. Colons are never hidden.
  - With campo_edit=0, nothing is hidden; the counter keeps running.
- RESET asserted mid-frame: outputs return to reset values on the next edge. After release, the first 3 CLK output blank/inactive while the pipeline refills.

Optional Feature:
- Macro: BORDE_MARCO_EN.
- Defined: pixels with video_on and (X==0 || X==639 || Y==0 || Y==479) output COLOR_FG, overriding the background. Evaluated in S1 and carried through the pipeline, so latency is unchanged.
- Undefined: no border logic; edge pixels follow the normal rules.

Decomposition:
- Package paquete_vga_rtc:
  - H_VISIBLE=640, V_VISIBLE=480;
  - GLYPH_COLON=10, GLYPH_BLANK=15;
  - CHAR_W=32, CHAR_H=64, SCALE_SHIFT=2;
  - field codes CAMPO_NINGUNO/HORA/MIN/SEG.
- Sub-module font_rom_digitos: 16 glyphs x 16 rows x 8 bits, 8-bit address {glyph,row}, registered output, 1-cycle read latency, unused glyphs all zero.

Test Plan:
- Reset: hold RESET 5 CLK -> rgb=0, hsync_out=1, vsync_out=1. Release -> the syncs track the inputs with exactly 3 CLK delay.
- Render: snapshot 12:34:56, drive X=X0+4 over rows Y0..Y0+63 -> rgb=FG/BG matches the glyph-1 ROM column; X=700 -> rgb=0.
- Snapshot: change seg_bcd from 8'h56 to 8'h57 at Y=100 -> seconds glyph still 6 for the remainder of the frame; 7 after the next vsync fall.
- Invalid BCD: min_bcd=8'hA3 -> char 3 renders all COLOR_BG; char 4 renders "3".
- Blink: campo_edit=2, BLINK_FRAMES=2 -> minute digits hidden on frames 2-3, visible on 4-5; hours, seconds and colons always visible.
- BORDE_MARCO_EN defined: pixel (0,0) and (639,479) -> COLOR_FG; undefined -> COLOR_BG at the same pixels.
